// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle MIPS control FSM with memory ready handshake and
//                wait-state timeout. Define MC_CONTROL_JAL_EN to decode JAL.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       SignExtend,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [3:0] c_st_boot   = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_memadr = 4'd3;
    localparam logic [3:0] c_st_memrd  = 4'd4;
    localparam logic [3:0] c_st_memwb  = 4'd5;
    localparam logic [3:0] c_st_memwr  = 4'd6;
    localparam logic [3:0] c_st_rtype  = 4'd7;
    localparam logic [3:0] c_st_aluwb  = 4'd8;
    localparam logic [3:0] c_st_immex  = 4'd9;
    localparam logic [3:0] c_st_immwb  = 4'd10;
    localparam logic [3:0] c_st_branch = 4'd11;
    localparam logic [3:0] c_st_jump   = 4'd12;
    localparam logic [3:0] c_st_fault  = 4'd15;

    localparam logic [5:0] c_op_rformat = 6'd0;
    localparam logic [5:0] c_op_jal     = 6'd3;
    localparam logic [5:0] c_op_beq     = 6'd4;
    localparam logic [5:0] c_op_addi    = 6'd8;
    localparam logic [5:0] c_op_andi    = 6'd12;
    localparam logic [5:0] c_op_lw      = 6'd35;
    localparam logic [5:0] c_op_sw      = 6'd43;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [5:0]        r_op;
    logic [WAIT_W-1:0] r_wait;
    logic              w_wait_st;
    logic              w_timeout;
    logic              w_legal;
    logic              w_andi;

    assign w_wait_st = (r_state == c_st_fetch) || (r_state == c_st_memrd) ||
                       (r_state == c_st_memwr);
    assign w_andi    = (r_op == c_op_andi);
    assign state     = r_state;

    generate
        if (WAIT_MAX == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = w_wait_st && !mem_ready &&
                               (r_wait == WAIT_W'(WAIT_MAX));
        end
    endgenerate

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            c_op_rformat, c_op_beq, c_op_addi,
            c_op_andi, c_op_lw, c_op_sw:       w_legal = 1'b1;
`ifdef MC_CONTROL_JAL_EN
            c_op_jal:                          w_legal = 1'b1;
`endif
            default:                           w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait counter restarts on any state change and on every accepted transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= '0;
            r_wait <= '0;
        end else begin
            if (r_state == c_st_decode) begin
                r_op <= opcode;
            end
            if ((w_next != r_state) || mem_ready) begin
                r_wait <= '0;
            end else if (w_wait_st && (r_wait != '1)) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_boot:   w_next = c_st_fetch;
            c_st_fetch: begin
                if (mem_ready)      w_next = c_st_decode;
                else if (w_timeout) w_next = c_st_fault;
            end
            c_st_decode: begin
                case (opcode)
                    c_op_lw, c_op_sw:      w_next = c_st_memadr;
                    c_op_rformat:          w_next = c_st_rtype;
                    c_op_addi, c_op_andi:  w_next = c_st_immex;
                    c_op_beq:              w_next = c_st_branch;
`ifdef MC_CONTROL_JAL_EN
                    c_op_jal:              w_next = c_st_jump;
`endif
                    default:               w_next = c_st_fetch;
                endcase
            end
            c_st_memadr: w_next = (r_op == c_op_lw) ? c_st_memrd : c_st_memwr;
            c_st_memrd: begin
                if (mem_ready)      w_next = c_st_memwb;
                else if (w_timeout) w_next = c_st_fault;
            end
            c_st_memwr: begin
                if (mem_ready)      w_next = c_st_fetch;
                else if (w_timeout) w_next = c_st_fault;
            end
            c_st_rtype:  w_next = c_st_aluwb;
            c_st_immex:  w_next = c_st_immwb;
            c_st_memwb, c_st_aluwb, c_st_immwb,
            c_st_branch, c_st_jump:  w_next = c_st_fetch;
            c_st_fault:  w_next = c_st_fault;
            // Unused encodings are treated as corruption and trapped.
            default:     w_next = c_st_fault;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        SignExtend  = 1'b1;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        fault       = 1'b0;
        case (r_state)
            c_st_fetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            c_st_decode: begin
                ALUSrcB    = 2'b11;
                illegal_op = !w_legal;
            end
            c_st_memadr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_st_memrd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            c_st_memwb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            c_st_memwr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            c_st_rtype: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            c_st_aluwb: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            c_st_immex, c_st_immwb: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = w_andi ? 2'b11 : 2'b00;
                SignExtend = !w_andi;
                RegWrite   = (r_state == c_st_immwb);
                instr_done = (r_state == c_st_immwb);
            end
            c_st_branch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
`ifdef MC_CONTROL_JAL_EN
            c_st_jump: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
            end
`endif
            c_st_fault:  fault = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Self-checking bench for multicycle_control: directed vector table, corner
// sequences, and randomized instructions against a phase-level model.
module tb_multicycle_control;

    localparam logic [3:0] c_s_boot   = 4'd0;
    localparam logic [3:0] c_s_fetch  = 4'd1;
    localparam logic [3:0] c_s_decode = 4'd2;
    localparam logic [3:0] c_s_memadr = 4'd3;
    localparam logic [3:0] c_s_memrd  = 4'd4;
    localparam logic [3:0] c_s_memwb  = 4'd5;
    localparam logic [3:0] c_s_memwr  = 4'd6;
    localparam logic [3:0] c_s_rtype  = 4'd7;
    localparam logic [3:0] c_s_aluwb  = 4'd8;
    localparam logic [3:0] c_s_immex  = 4'd9;
    localparam logic [3:0] c_s_immwb  = 4'd10;
    localparam logic [3:0] c_s_branch = 4'd11;
    localparam logic [3:0] c_s_jump   = 4'd12;
    localparam logic [3:0] c_s_fault  = 4'd15;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw, asa, se;
        logic [1:0] rd, mtr, asb, aop, pcs;
        logic       done, ill, flt;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        ctrl_t      c;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic       rw, done, ill, mw;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, ALUSrcA, SignExtend;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op, fault;
    logic [3:0] state;
    ctrl_t      w_act;

    int total = 0;
    int bad   = 0;

    ctrl_t e_boot, e_fetch_stall, e_fetch_go, e_decode, e_decode_ill, e_memadr;
    ctrl_t e_memrd, e_memwb, e_memwr_stall, e_memwr_go, e_rtype, e_aluwb;
    ctrl_t e_addi_ex, e_addi_wb, e_andi_ex, e_andi_wb, e_branch, e_jump, e_fault;

    vec_t vt[$];
    ent_t q[$];

    always #5 clk = ~clk;

    assign w_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    RegWrite, ALUSrcA, SignExtend, RegDst, MemtoReg, ALUSrcB,
                    ALUOp, PCSource, instr_done, illegal_op, fault};

    multicycle_control #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .SignExtend(SignExtend),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
        .illegal_op(illegal_op), .fault(fault), .state(state)
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input logic mr);
        @(negedge clk);
        opcode    = op;
        mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_state", 0, 32'(state), 32'(c_s_boot));
        chk("rst_ctrl", 0, 32'(w_act), 32'(e_boot));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("boot_state", 0, 32'(state), 32'(c_s_boot));
    endtask

    function automatic void add(input logic [5:0] op, input logic mr,
                                input logic [3:0] st, input ctrl_t c);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.c = c;
        vt.push_back(v);
    endfunction

    function automatic void pe(input logic [5:0] op, input logic mr, input logic [3:0] st,
                               input logic rw, input logic done, input logic ill,
                               input logic mw);
        ent_t e;
        e.op = op; e.mr = mr; e.st = st;
        e.rw = rw; e.done = done; e.ill = ill; e.mw = mw;
        q.push_back(e);
    endfunction

    task automatic init_exp();
        ctrl_t c;
        c = '0; c.se = 1'b1; e_boot = c;
        c = e_boot; c.mrd = 1'b1; c.asb = 2'b01; e_fetch_stall = c;
        c.pcw = 1'b1; c.irw = 1'b1; e_fetch_go = c;
        c = e_boot; c.asb = 2'b11; e_decode = c;
        c.ill = 1'b1; e_decode_ill = c;
        c = e_boot; c.asa = 1'b1; c.asb = 2'b10; e_memadr = c; e_addi_ex = c;
        c.rw = 1'b1; c.done = 1'b1; e_addi_wb = c;
        c = e_addi_ex; c.aop = 2'b11; c.se = 1'b0; e_andi_ex = c;
        c.rw = 1'b1; c.done = 1'b1; e_andi_wb = c;
        c = e_boot; c.mrd = 1'b1; c.iord = 1'b1; e_memrd = c;
        c = e_boot; c.rw = 1'b1; c.mtr = 2'b01; c.done = 1'b1; e_memwb = c;
        c = e_boot; c.mwr = 1'b1; c.iord = 1'b1; e_memwr_stall = c;
        c.done = 1'b1; e_memwr_go = c;
        c = e_boot; c.asa = 1'b1; c.aop = 2'b10; e_rtype = c;
        c = e_boot; c.rw = 1'b1; c.rd = 2'b01; c.done = 1'b1; e_aluwb = c;
        c = e_boot; c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
        c.done = 1'b1; e_branch = c;
        c = e_boot; c.pcw = 1'b1; c.pcs = 2'b10; c.rw = 1'b1; c.rd = 2'b10;
        c.mtr = 2'b10; c.done = 1'b1; e_jump = c;
        c = e_boot; c.flt = 1'b1; e_fault = c;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [9];
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        init_exp();

        // Directed table; post-DECODE rows drive unrelated opcodes on purpose.
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd0,  1, c_s_decode, e_decode);
        add(6'd35, 1, c_s_rtype,  e_rtype);
        add(6'd43, 1, c_s_aluwb,  e_aluwb);
        add(6'd9,  1, c_s_fetch,  e_fetch_go);
        add(6'd35, 1, c_s_decode, e_decode);
        add(6'd43, 0, c_s_memadr, e_memadr);
        add(6'd43, 0, c_s_memrd,  e_memrd);
        add(6'd0,  0, c_s_memrd,  e_memrd);
        add(6'd0,  0, c_s_memrd,  e_memrd);
        add(6'd0,  1, c_s_memrd,  e_memrd);
        add(6'd0,  0, c_s_memwb,  e_memwb);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd12, 1, c_s_decode, e_decode);
        add(6'd8,  0, c_s_immex,  e_andi_ex);
        add(6'd8,  1, c_s_immwb,  e_andi_wb);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd8,  1, c_s_decode, e_decode);
        add(6'd12, 1, c_s_immex,  e_addi_ex);
        add(6'd12, 0, c_s_immwb,  e_addi_wb);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd63, 1, c_s_decode, e_decode_ill);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
`ifdef MC_CONTROL_JAL_EN
        add(6'd3,  1, c_s_decode, e_decode);
        add(6'd0,  1, c_s_jump,   e_jump);
`else
        add(6'd3,  1, c_s_decode, e_decode_ill);
`endif
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd4,  1, c_s_decode, e_decode);
        add(6'd0,  0, c_s_branch, e_branch);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd43, 1, c_s_decode, e_decode);
        add(6'd35, 1, c_s_memadr, e_memadr);
        add(6'd35, 0, c_s_memwr,  e_memwr_stall);
        add(6'd35, 1, c_s_memwr,  e_memwr_go);
        add(6'd0,  0, c_s_fetch,  e_fetch_stall);
        add(6'd0,  1, c_s_fetch,  e_fetch_go);
        add(6'd4,  1, c_s_decode, e_decode);
        add(6'd0,  1, c_s_branch, e_branch);

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].op, vt[i].mr);
            chk("vec_state", i, 32'(state), 32'(vt[i].st));
            chk("vec_ctrl", i, 32'(w_act), 32'(vt[i].c));
        end

        // Timeout: 16 stalled FETCH cycles then sticky FAULT.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(6'd0, 1'b0);
            chk("to_fetch", i, 32'(state), 32'(c_s_fetch));
            chk("to_fetch_ctrl", i, 32'(w_act), 32'(e_fetch_stall));
        end
        for (int i = 0; i < 3; i++) begin
            step(6'd0, 1'b1);
            chk("to_fault", i, 32'(state), 32'(c_s_fault));
            chk("to_fault_ctrl", i, 32'(w_act), 32'(e_fault));
        end

        // Accept on the 16th FETCH cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 15; i++) step(6'd0, 1'b0);
        step(6'd0, 1'b1);
        chk("acc_fetch", 0, 32'(w_act), 32'(e_fetch_go));
        step(6'd0, 1'b1);
        chk("acc_decode", 0, 32'(state), 32'(c_s_decode));

        // Reset during MEMWR aborts asynchronously.
        do_reset();
        step(6'd0, 1'b1);
        step(6'd43, 1'b1);
        step(6'd0, 1'b1);
        step(6'd0, 1'b0);
        chk("mw_state", 0, 32'(state), 32'(c_s_memwr));
        chk("mw_write", 0, 32'(MemWrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mw_abort_state", 0, 32'(state), 32'(c_s_boot));
        chk("mw_abort_write", 0, 32'(MemWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mw_boot", 0, 32'(state), 32'(c_s_boot));
        step(6'd0, 1'b1);
        chk("mw_refetch", 0, 32'(state), 32'(c_s_fetch));

        // Randomized instructions against a phase-level model.
        ops = '{6'd0, 6'd3, 6'd4, 6'd8, 6'd12, 6'd35, 6'd43, 6'd63, 6'd17};
        do_reset();
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int         k;
            logic       lgl;
            op = ops[$urandom_range(0, 8)];
            q.delete();
            k = $urandom_range(0, 3);
            for (int s = 0; s < k; s++) pe(6'($urandom_range(0, 63)), 1'b0, c_s_fetch, 0, 0, 0, 0);
            pe(6'($urandom_range(0, 63)), 1'b1, c_s_fetch, 0, 0, 0, 0);
            lgl = (op == 6'd0) || (op == 6'd4) || (op == 6'd8) || (op == 6'd12) ||
                  (op == 6'd35) || (op == 6'd43);
`ifdef MC_CONTROL_JAL_EN
            if (op == 6'd3) lgl = 1'b1;
`endif
            pe(op, 1'($urandom_range(0, 1)), c_s_decode, 0, 0, !lgl, 0);
            k = $urandom_range(0, 3);
            case (op)
                6'd35: begin
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_memadr, 0, 0, 0, 0);
                    for (int s = 0; s < k; s++) pe(6'($urandom_range(0, 63)), 1'b0, c_s_memrd, 0, 0, 0, 0);
                    pe(6'($urandom_range(0, 63)), 1'b1, c_s_memrd, 0, 0, 0, 0);
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_memwb, 1, 1, 0, 0);
                end
                6'd43: begin
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_memadr, 0, 0, 0, 0);
                    for (int s = 0; s < k; s++) pe(6'($urandom_range(0, 63)), 1'b0, c_s_memwr, 0, 0, 0, 1);
                    pe(6'($urandom_range(0, 63)), 1'b1, c_s_memwr, 0, 1, 0, 1);
                end
                6'd0: begin
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_rtype, 0, 0, 0, 0);
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_aluwb, 1, 1, 0, 0);
                end
                6'd8, 6'd12: begin
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_immex, 0, 0, 0, 0);
                    pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_immwb, 1, 1, 0, 0);
                end
                6'd4: pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_branch, 0, 1, 0, 0);
                default: begin
                    if (lgl) pe(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), c_s_jump, 1, 1, 0, 0);
                end
            endcase
            for (int i = 0; i < q.size(); i++) begin
                step(q[i].op, q[i].mr);
                chk("rand", n * 16 + i,
                    32'({state, RegWrite, instr_done, illegal_op, MemWrite}),
                    32'({q[i].st, q[i].rw, q[i].done, q[i].ill, q[i].mw}));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
